// File: rtl/cmd_retry_host.sv
// cmd_retry_host: host-side command sequencer for the RemoteComm link.
// A small circular queue of {cmd,data} entries feeds an FSM that issues one
// command at a time, waits for RemoteComm to finish transmitting, then checks
// the response byte against ACK_BYTE. Each attempt has its own timeout, and a
// command is re-sent a bounded number of times before it completes with NAK
// or TIMEOUT status. The head entry stays in the queue until the command
// finishes, so a reset mid-transaction simply abandons it.
module cmd_retry_host #(
    parameter int         DEPTH       = 4,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         MAX_RETRY   = 2,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    localparam int        RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_cmd,
    input  logic [15:0]   push_data,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          send_cmd,
    output logic [7:0]    cmd,
    output logic [15:0]   data,
    input  logic          cmd_sent,
    input  logic          resp_rdy,
    input  logic [7:0]    resp,
    output logic          clr_resp_rdy,
    output logic          busy,
    output logic          done,
    output logic [1:0]    done_status,
    output logic [RW-1:0] retry_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_NAK     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        DONE
    } state_t;

    // Queue storage and bookkeeping
    logic [7:0]    mem_cmd_q  [DEPTH];
    logic [7:0]    mem_cmd_d  [DEPTH];
    logic [15:0]   mem_data_q [DEPTH];
    logic [15:0]   mem_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;

    // Sequencer state
    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    status_q, status_d;

    logic          push_ok;
    logic          pop;

    // A push is only taken when the queue was not full at the start of the
    // cycle, even if the head is popped in the same cycle.
    assign push_ok = push & ~full_q;
    assign pop     = (state_q == DONE);

    // Queue next-state: write at the tail, retire the head when a command completes
    always_comb begin
        mem_cmd_d  = mem_cmd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_ok) begin
            mem_cmd_d[wr_ptr_q]  = push_cmd;
            mem_data_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);
        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (push & full_q);
    end

    // Queue registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_cmd_q[i]  <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            mem_cmd_q  <= mem_cmd_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sequencer next-state and Mealy strobes
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        status_d     = status_q;
        send_cmd     = 1'b0;
        clr_resp_rdy = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    cmd_d   = mem_cmd_q[rd_ptr_q];
                    data_d  = mem_data_q[rd_ptr_q];
                    state_d = SEND;
                end
            end

            SEND: begin
                send_cmd = 1'b1;
                state_d  = WAIT_SENT;
            end

            WAIT_SENT: begin
                if (cmd_sent) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + TW'(1);
                end
                if (resp_rdy) begin
                    // A response arriving in the final timeout cycle still counts.
                    clr_resp_rdy = 1'b1;
                    if (resp == ACK_BYTE) begin
                        status_d = ST_ACK;
                        state_d  = DONE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        status_d = ST_NAK;
                        state_d  = DONE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        status_d = ST_TIMEOUT;
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                retry_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            data_q   <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            status_q <= status_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign ovf         = ovf_q;
    assign cmd         = cmd_q;
    assign data        = data_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign done_status = status_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_cmd_retry_host.sv
// Directed bench for cmd_retry_host with a short timeout so retries are cheap.
module tb_cmd_retry_host;

    logic        clk;
    logic        rst;
    logic        push;
    logic [7:0]  push_cmd;
    logic [15:0] push_data;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        send_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;
    logic        busy;
    logic        done;
    logic [1:0]  done_status;
    logic [1:0]  retry_cnt;

    int testCount = 0;
    int failCount = 0;
    int sendCount = 0;
    int clrCount  = 0;
    int doneCount = 0;

    int sendBase;
    int clrBase;
    int doneBase;

    cmd_retry_host #(
        .DEPTH      (4),
        .TIMEOUT_CYC(1000),
        .MAX_RETRY  (2),
        .ACK_BYTE   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_cmd    (push_cmd),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .ovf         (ovf),
        .send_cmd    (send_cmd),
        .cmd         (cmd),
        .data        (data),
        .cmd_sent    (cmd_sent),
        .resp_rdy    (resp_rdy),
        .resp        (resp),
        .clr_resp_rdy(clr_resp_rdy),
        .busy        (busy),
        .done        (done),
        .done_status (done_status),
        .retry_cnt   (retry_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshake strobes as the DUT sees them at each active edge
    always @(posedge clk) begin
        if (!rst) begin
            if (send_cmd)     sendCount++;
            if (clr_resp_rdy) clrCount++;
            if (done)         doneCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle push, starting at a negedge and ending at the next one
    task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
        push      = 1'b1;
        push_cmd  = c;
        push_data = d;
        @(negedge clk);
        push      = 1'b0;
    endtask

    // Wait (bounded) for send_cmd and check the command being issued
    task automatic sendPhase(input string tag, input logic [7:0] c, input logic [15:0] d);
        int n = 0;
        while (!send_cmd && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_send"}, 32'(send_cmd), 32'd1);
        checkOutput({tag, "_cmd"},  32'(cmd),  32'(c));
        checkOutput({tag, "_data"}, 32'(data), 32'(d));
    endtask

    // RemoteComm stand-in: finish transmitting, then either answer after
    // 'delay' cycles in WAIT_RESP or stay silent and measure the timeout
    task automatic answerPhase(input string tag, input logic answer,
                               input logic [7:0] r, input int delay);
        int n = 0;
        @(negedge clk);
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
        if (answer) begin
            repeat (delay) @(negedge clk);
            resp_rdy = 1'b1;
            resp     = r;
            @(negedge clk);
            resp_rdy = 1'b0;
            resp     = 8'h00;
        end else begin
            while (!(send_cmd || done) && n < 1100) begin
                @(negedge clk);
                n++;
            end
            checkOutput({tag, "_timeout_cycles"}, 32'(n), 32'd1000);
        end
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        push      = 1'b0;
        push_cmd  = 8'h00;
        push_data = 16'h0000;
        cmd_sent  = 1'b0;
        resp_rdy  = 1'b0;
        resp      = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_empty",  32'(empty), 32'd1);
        checkOutput("rst_full",   32'(full),  32'd0);
        checkOutput("rst_ovf",    32'(ovf),   32'd0);
        checkOutput("rst_busy",   32'(busy),  32'd0);
        checkOutput("rst_send",   32'(send_cmd), 32'd0);
        checkOutput("rst_done",   32'(done),  32'd0);
        checkOutput("rst_status", 32'(done_status), 32'd0);
        checkOutput("rst_retry",  32'(retry_cnt), 32'd0);
        checkOutput("rst_cmd",    32'(cmd),   32'd0);
        checkOutput("rst_data",   32'(data),  32'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Single command, immediate ACK, with push-to-send latency
        sendBase = sendCount; clrBase = clrCount; doneBase = doneCount;
        applyStimulus(8'h05, 16'h0020);
        checkOutput("lat_empty_fell", 32'(empty), 32'd0);
        checkOutput("lat_no_send_yet", 32'(send_cmd), 32'd0);
        @(negedge clk);
        checkOutput("lat_send", 32'(send_cmd), 32'd1);
        checkOutput("lat_busy", 32'(busy), 32'd1);
        sendPhase("ack", 8'h05, 16'h0020);
        answerPhase("ack", 1'b1, 8'hA5, 3);
        waitDone("ack");
        checkOutput("ack_status", 32'(done_status), 32'd0);
        checkOutput("ack_retry",  32'(retry_cnt), 32'd0);
        @(negedge clk);
        checkOutput("ack_done_one_cycle", 32'(done), 32'd0);
        checkOutput("ack_status_held", 32'(done_status), 32'd0);
        checkOutput("ack_sends", 32'(sendCount - sendBase), 32'd1);
        checkOutput("ack_clrs",  32'(clrCount - clrBase), 32'd1);
        checkOutput("ack_dones", 32'(doneCount - doneBase), 32'd1);
        checkOutput("ack_empty", 32'(empty), 32'd1);

        // Two NAKs then ACK
        sendBase = sendCount; clrBase = clrCount;
        applyStimulus(8'h05, 16'h0020);
        sendPhase("nak1", 8'h05, 16'h0020);
        answerPhase("nak1", 1'b1, 8'h5A, 3);
        sendPhase("nak2", 8'h05, 16'h0020);
        answerPhase("nak2", 1'b1, 8'h5A, 3);
        sendPhase("nak3", 8'h05, 16'h0020);
        answerPhase("nak3", 1'b1, 8'hA5, 3);
        waitDone("nak");
        checkOutput("nak_status", 32'(done_status), 32'd0);
        checkOutput("nak_retry",  32'(retry_cnt), 32'd2);
        @(negedge clk);
        checkOutput("nak_sends", 32'(sendCount - sendBase), 32'd3);
        checkOutput("nak_clrs",  32'(clrCount - clrBase), 32'd3);
        checkOutput("nak_retry_cleared", 32'(retry_cnt), 32'd0);

        // No response at all: three timed-out attempts
        sendBase = sendCount; clrBase = clrCount;
        applyStimulus(8'h02, 16'h1234);
        sendPhase("to1", 8'h02, 16'h1234);
        answerPhase("to1", 1'b0, 8'h00, 0);
        sendPhase("to2", 8'h02, 16'h1234);
        answerPhase("to2", 1'b0, 8'h00, 0);
        sendPhase("to3", 8'h02, 16'h1234);
        answerPhase("to3", 1'b0, 8'h00, 0);
        waitDone("to");
        checkOutput("to_status", 32'(done_status), 32'd2);
        checkOutput("to_retry",  32'(retry_cnt), 32'd2);
        @(negedge clk);
        checkOutput("to_sends", 32'(sendCount - sendBase), 32'd3);
        checkOutput("to_clrs",  32'(clrCount - clrBase), 32'd0);
        checkOutput("to_status_held", 32'(done_status), 32'd2);

        // Five back-to-back pushes while the head sits in WAIT_SENT
        doneBase = doneCount;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checkOutput("fill_full_after_4", 32'(full), 32'd1);
                checkOutput("fill_ovf_before_5", 32'(ovf), 32'd0);
            end
            push      = 1'b1;
            push_cmd  = 8'h10 + 8'(i);
            push_data = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        push = 1'b0;
        checkOutput("fill_ovf",   32'(ovf),  32'd1);
        checkOutput("fill_full",  32'(full), 32'd1);
        checkOutput("fill_busy",  32'(busy), 32'd1);
        checkOutput("fill_head_cmd",  32'(cmd),  32'h10);
        checkOutput("fill_head_data", 32'(data), 32'h1000);
        answerPhase("fill0", 1'b1, 8'hA5, 2);
        waitDone("fill0");
        checkOutput("fill0_order", 32'(cmd), 32'h10);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b_idle_gap", 32'(send_cmd), 32'd0);
            @(negedge clk);
            checkOutput("b2b_send_2_after_done", 32'(send_cmd), 32'd1);
            sendPhase("fill", 8'h10 + 8'(i), 16'h1000 + 16'(i));
            answerPhase("fill", 1'b1, 8'hA5, 2);
            waitDone("fill");
            checkOutput("fill_order", 32'(cmd), 32'(8'h10 + 8'(i)));
            checkOutput("fill_status", 32'(done_status), 32'd0);
        end
        @(negedge clk);
        checkOutput("fill_dones", 32'(doneCount - doneBase), 32'd4);
        checkOutput("fill_drained_empty", 32'(empty), 32'd1);
        checkOutput("fill_drained_full",  32'(full),  32'd0);
        checkOutput("fill_ovf_sticky",    32'(ovf),   32'd1);
        checkOutput("fill_idle", 32'(busy), 32'd0);

        // Response lands exactly in the last timeout cycle
        sendBase = sendCount;
        applyStimulus(8'h07, 16'h0777);
        sendPhase("edge", 8'h07, 16'h0777);
        answerPhase("edge", 1'b1, 8'hA5, 999);
        checkOutput("edge_done", 32'(done), 32'd1);
        checkOutput("edge_status", 32'(done_status), 32'd0);
        checkOutput("edge_retry",  32'(retry_cnt), 32'd0);
        @(negedge clk);
        checkOutput("edge_sends", 32'(sendCount - sendBase), 32'd1);

        // Reset while waiting for a response with two entries queued
        applyStimulus(8'h21, 16'h2100);
        applyStimulus(8'h22, 16'h2200);
        sendPhase("rstmid", 8'h21, 16'h2100);
        @(negedge clk);
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
        checkOutput("rstmid_ovf_before",  32'(ovf),  32'd1);
        sendBase = sendCount; doneBase = doneCount;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_empty", 32'(empty), 32'd1);
        checkOutput("rstmid_busy",  32'(busy),  32'd0);
        checkOutput("rstmid_send",  32'(send_cmd), 32'd0);
        checkOutput("rstmid_ovf",   32'(ovf),   32'd0);
        checkOutput("rstmid_cmd",   32'(cmd),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rstmid_no_done", 32'(doneCount - doneBase), 32'd0);
        checkOutput("rstmid_no_send", 32'(sendCount - sendBase), 32'd0);
        checkOutput("rstmid_still_empty", 32'(empty), 32'd1);
        checkOutput("rstmid_still_idle",  32'(busy),  32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
